uart_tx_rr_scheduler: RTL and testbench

//  Shares one UART transmit line among NUM_REQ byte sources using round-robin arbitration.

---
 rtl/uart_tx_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_uart_tx_rr_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_rr_scheduler.sv
// Round-robin arbiter feeding a single UART transmitter.
// One granted byte is serialized as start, data LSB-first, optional parity, stop bit(s).
module uart_tx_rr_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        baud_tick,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        frame_done
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_e;

    state_e                           state_q, state_d;
    logic                             tx_q, tx_d;
    logic                             done_q, done_d;
    logic [PTR_W-1:0]                 last_q, last_d;
    logic [PTR_W-1:0]                 grant_q, grant_d;
    logic [DATA_W-1:0]                data_q, data_d;
    logic [DATA_W-1:0]                shift_q, shift_d;
    logic [CNT_W-1:0]                 bit_cnt_q, bit_cnt_d;
    logic                             stop_cnt_q, stop_cnt_d;

    logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_a;
    logic [PTR_W-1:0]                 win;
    logic                             found;
    logic                             par;

    assign req_data_a = req_data;
    assign par        = (PARITY_ODD != 0) ? ~^data_q : ^data_q;

    // Walk candidates from farthest to nearest after last_q so the nearest valid one wins.
    always_comb begin
        win   = '0;
        found = |req_valid;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[PTR_W'((int'(last_q) + k) % NUM_REQ)])
                win = PTR_W'((int'(last_q) + k) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            last_q     <= PTR_W'(NUM_REQ - 1);
            grant_q    <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        last_d     = last_q;
        grant_d    = grant_q;
        data_d     = data_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (found) begin
                    data_d  = req_data_a[win];
                    grant_d = win;
                    last_d  = win;
                    state_d = SYNC;
                end
            end
            SYNC: if (baud_tick) begin
                tx_d    = 1'b0;
                state_d = START;
            end
            START: if (baud_tick) begin
                tx_d      = data_q[0];
                shift_d   = data_q >> 1;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: if (baud_tick) begin
                if (bit_cnt_q < CNT_W'(DATA_W - 1)) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (PARITY_EN != 0) begin
                    tx_d    = par;
                    state_d = PARITY;
                end else begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            PARITY: if (baud_tick) begin
                tx_d       = 1'b1;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
            STOP: if (baud_tick) begin
                if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        req_ready = '0;
        if (state_q == IDLE && found)
            req_ready = NUM_REQ'(1) << win;
    end

    assign tx         = tx_q;
    assign grant_id   = grant_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_uart_tx_rr_scheduler.sv
// Randomized scoreboard bench: three parameter sets run side by side, each with its own
// requester driver / grant model and a tx-line decoder that checks frames against expectations.
module tb_uart_tx_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick = 1'b0;
    logic hold_all = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [cfg%0d] %s: got %0h, want %0h", inst, nm, act, exp);
        end
    endtask

    // Bit strobe: one clock wide, period randomly 3..6 clocks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt == 0) begin
                tick = 1'b1;
                cnt  = $urandom_range(2, 5);
            end else begin
                tick = 1'b0;
                cnt--;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NR  = (g == 0) ? 4 : (g == 1) ? 3 : 8;
        localparam int DW  = (g == 0) ? 8 : (g == 1) ? 7 : 5;
        localparam int PE  = (g == 0) ? 0 : 1;
        localparam int PO  = (g == 2) ? 1 : 0;
        localparam int SBN = (g == 0) ? 1 : 2;
        localparam int GW  = $clog2(NR);

        logic [NR-1:0]    rv;
        logic [NR-1:0]    rr;
        logic [NR*DW-1:0] rd;
        logic             tx, busy, fd;
        logic [GW-1:0]    gid;
        logic [DW-1:0]    rq [NR][$];
        logic [DW-1:0]    sb [$];
        int acc_n = 0, done_n = 0, mlast = NR - 1, mgid = 0;
        int mph = 0, bi = 0, sc = 0;
        bit drained = 1'b0;

        uart_tx_rr_scheduler #(
            .NUM_REQ(NR), .DATA_W(DW), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SBN)
        ) dut (
            .clk(clk), .rst_n(rst_n), .baud_tick(tick),
            .req_valid(rv), .req_data(rd), .req_ready(rr),
            .tx(tx), .busy(busy), .grant_id(gid), .frame_done(fd)
        );

        initial begin : rst_chk
            repeat (3) @(negedge clk);
            chk(g, "rst_tx", 64'(tx), 64'(1));
            chk(g, "rst_busy", 64'(busy), 64'(0));
            chk(g, "rst_frame_done", 64'(fd), 64'(0));
            chk(g, "rst_grant_id", 64'(gid), 64'(0));
            chk(g, "rst_req_ready", 64'(rr), 64'(0));
        end

        // Requester driver + grant model: line free => nearest valid after last grant wins.
        initial begin : drv
            logic [NR-1:0] er;
            int win, c;
            rv = '0;
            rd = '0;
            for (int i = 0; i < NR; i++)
                repeat ($urandom_range(4, 12)) rq[i].push_back(DW'($urandom));
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    rv = '0;
                    mlast = NR - 1;
                    mgid = 0;
                    continue;
                end
                chk(g, "grant_id", 64'(gid), 64'(mgid));
                for (int i = 0; i < NR; i++) begin
                    rv[i] = (rq[i].size() > 0) && (hold_all || acc_n < 2 * NR || $urandom_range(3) != 0);
                    rd[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : DW'($urandom);
                end
                #1;
                er = '0;
                win = -1;
                if (acc_n == done_n) begin
                    for (int k = 1; k <= NR; k++) begin
                        c = (mlast + k) % NR;
                        if (win < 0 && rv[c]) win = c;
                    end
                end
                if (win >= 0) er[win] = 1'b1;
                chk(g, "req_ready", 64'(rr), 64'(er));
                if (win >= 0) begin
                    sb.push_back(rq[win].pop_front());
                    mlast = win;
                    mgid = win;
                    acc_n++;
                end
            end
        end

        // Line decoder: samples tx on tick cycles, i.e. the bit that ends at the coming edge.
        initial begin : mon
            logic [DW-1:0] cap;
            logic ptx, ptick;
            bit pdone, e;
            cap = '0;
            ptx = 1'b1;
            ptick = 1'b0;
            pdone = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    mph = 0;
                    pdone = 1'b0;
                    sb.delete();
                    done_n = acc_n;
                    ptx = 1'b1;
                    ptick = 1'b0;
                    drained = 1'b0;
                    continue;
                end
                if (tx !== ptx) chk(g, "tx_moves_on_tick", 64'(ptick), 64'(1));
                chk(g, "frame_done", 64'(fd), 64'(pdone));
                if (pdone) done_n++;
                chk(g, "busy", 64'(busy), 64'(acc_n != done_n));
                pdone = 1'b0;
                if (tick) begin
                    case (mph)
                        0: if (tx == 1'b0) begin
                            mph = 1;
                            bi = 0;
                        end
                        1: begin
                            cap[bi] = tx;
                            bi++;
                            sc = 0;
                            if (bi == DW) mph = (PE != 0) ? 2 : 3;
                        end
                        2: begin
                            chk(g, "parity", 64'(tx), 64'((PO != 0) ? ~^cap : ^cap));
                            mph = 3;
                        end
                        default: begin
                            chk(g, "stop_bit", 64'(tx), 64'(1));
                            sc++;
                            if (sc == SBN) begin
                                if (sb.size() == 0) chk(g, "frame_expected", 64'(0), 64'(1));
                                else chk(g, "data", 64'(cap), 64'(sb.pop_front()));
                                mph = 0;
                                pdone = 1'b1;
                            end
                        end
                    endcase
                end
                ptx = tx;
                ptick = tick;
                e = 1'b1;
                for (int i = 0; i < NR; i++) if (rq[i].size() != 0) e = 1'b0;
                drained = e && (acc_n == done_n) && (sb.size() == 0) && (mph == 0) && !pdone;
            end
        end
    end

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        t = 0;
        while (!(gi[0].drained && gi[1].drained && gi[2].drained) && t < 30000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(0, "random_traffic_drained", 64'(t < 30000), 64'(1));

        // Abort a frame during data bit 3 of 0xA5 (bit 3 is 0, so the jump to 1 is visible).
        gi[0].rq[0].push_back(8'hA5);
        t = 0;
        while (!(gi[0].mph == 1 && gi[0].bi == 3) && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(0, "reached_bit3", 64'(t < 2000), 64'(1));
        @(negedge clk);
        #2;
        chk(0, "pre_abort_tx_bit3", 64'(gi[0].tx), 64'(0));
        chk(0, "pre_abort_busy", 64'(gi[0].busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk(0, "abort_tx_high", 64'(gi[0].tx), 64'(1));
        chk(0, "abort_busy_low", 64'(gi[0].busy), 64'(0));
        chk(0, "abort_no_frame_done", 64'(gi[0].fd), 64'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        hold_all = 1'b1;
        gi[0].rq[2].push_back(8'h3C);
        gi[0].rq[0].push_back(8'h96);
        t = 0;
        while (gi[0].rr == 4'b0000 && t < 200) begin
            @(negedge clk);
            #2;
            t++;
        end
        chk(0, "post_reset_first_ready", 64'(gi[0].rr), 64'(4'b0001));

        t = 0;
        while (!(gi[0].drained && gi[1].drained && gi[2].drained) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(0, "post_reset_drained", 64'(t < 5000), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
